// File: rtl/layer_stack.sv
// rtl/layer_stack.sv - N-layer drawing controller: layer select, tool routing, clear engine, priority resolver
// Build option LAYER_STACK_SKIP_HIDDEN_EN: layer advance skips hidden layers.
module layer_stack #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LAYERS      = 4,
  parameter int COLOR_WIDTH = 3,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int LW = $clog2(LAYERS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          layer_next,
  input  logic [LAYERS-1:0]             visible,
  input  logic                          tool_en,
  input  logic [XW-1:0]                 tool_x,
  input  logic [YW-1:0]                 tool_y,
  input  logic [COLOR_WIDTH-1:0]        tool_color,
  input  logic                          clear_req,
  input  logic [LAYERS*COLOR_WIDTH-1:0] layer_rd_color,
  output logic [LAYERS-1:0]             wr_en,
  output logic [XW-1:0]                 wr_x,
  output logic [YW-1:0]                 wr_y,
  output logic [COLOR_WIDTH-1:0]        wr_color,
  output logic [LW-1:0]                 active_layer,
  output logic                          busy,
  output logic [COLOR_WIDTH-1:0]        pix_color,
  output logic                          pix_opaque,
  output logic [LW-1:0]                 pix_layer
);

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = '0;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  state_t state;

  logic next_q, next_qq, clr_q, clr_qq;
  logic next_edge, clr_edge, act_vis;
  logic [LW-1:0] advance_layer;

  function automatic logic [LAYERS-1:0] layer_onehot(input logic [LW-1:0] l);
    layer_onehot = '0;
    for (int i = 0; i < LAYERS; i++)
      if (l == LW'(i + 1)) layer_onehot[i] = 1'b1;
  endfunction

`ifdef LAYER_STACK_SKIP_HIDDEN_EN
  // Search L+1, L+2, ... with wrap; stay on L if nothing else is visible.
  function automatic logic [LW-1:0] next_layer(input logic [LW-1:0] cur,
                                               input logic [LAYERS-1:0] vis);
    logic found;
    int   cand;
    next_layer = cur;
    found = 1'b0;
    for (int k = 1; k < LAYERS; k++) begin
      cand = (int'(cur) - 1 + k) % LAYERS;
      if (!found && vis[cand]) begin
        next_layer = LW'(cand + 1);
        found = 1'b1;
      end
    end
  endfunction

  assign advance_layer = next_layer(active_layer, visible);
`else
  function automatic logic [LW-1:0] next_layer(input logic [LW-1:0] cur);
    next_layer = (cur == LW'(LAYERS)) ? LW'(1) : cur + LW'(1);
  endfunction

  assign advance_layer = next_layer(active_layer);
`endif

  assign next_edge = next_q & ~next_qq;
  assign clr_edge  = clr_q & ~clr_qq;
  assign act_vis   = |(visible & layer_onehot(active_layer));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      active_layer <= LW'(1);
      busy         <= 1'b0;
      wr_en        <= '0;
      wr_x         <= '0;
      wr_y         <= '0;
      wr_color     <= '0;
      next_q       <= 1'b0;
      next_qq      <= 1'b0;
      clr_q        <= 1'b0;
      clr_qq       <= 1'b0;
    end else begin
      next_q  <= layer_next;
      next_qq <= next_q;
      clr_q   <= clear_req;
      clr_qq  <= clr_q;
      case (state)
        S_IDLE: begin
          wr_en <= '0;
          if (tool_en && act_vis) begin
            wr_en    <= layer_onehot(active_layer);
            wr_x     <= tool_x;
            wr_y     <= tool_y;
            wr_color <= tool_color;
          end
          // A clear edge claims the bus and beats a simultaneous advance.
          if (clr_edge) begin
            state    <= S_CLEAR;
            busy     <= 1'b1;
            wr_en    <= layer_onehot(active_layer);
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= COLOR_NONE;
          end else if (next_edge) begin
            active_layer <= advance_layer;
          end
        end
        S_CLEAR: begin
          // wr_en keeps the target latched on entry; wr_x/wr_y are the sweep counter.
          if (wr_x == X_LAST && wr_y == Y_LAST) begin
            state <= S_DONE;
            wr_en <= '0;
          end else if (wr_x == X_LAST) begin
            wr_x <= '0;
            wr_y <= wr_y + YW'(1);
          end else begin
            wr_x <= wr_x + XW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          wr_en <= '0;
        end
      endcase
    end
  end

  logic [COLOR_WIDTH-1:0] win_color;
  logic [LW-1:0]          win_layer;

  // Ascending scan: the last qualifying layer is the highest-numbered one.
  always_comb begin
    win_color = COLOR_NONE;
    win_layer = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (visible[i] && layer_rd_color[i*COLOR_WIDTH +: COLOR_WIDTH] != COLOR_NONE) begin
        win_color = layer_rd_color[i*COLOR_WIDTH +: COLOR_WIDTH];
        win_layer = LW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_color  <= '0;
      pix_opaque <= 1'b0;
      pix_layer  <= '0;
    end else begin
      pix_color  <= win_color;
      pix_opaque <= (win_layer != '0);
      pix_layer  <= win_layer;
    end
  end

endmodule
